// File: rtl/obf_unlock_sequencer.sv
// Unlock controller for the obfuscated toy FSM core: replays a key sequence, settles, checks the signature.
// Optional OBF_LOCKOUT_EN: MAX_RETRY failures park the block in LOCKOUT until rst.
module obf_unlock_sequencer #(
    parameter int DW         = 8,
    parameter int OPW        = 2,
    parameter int KEY_LEN    = 4,
    parameter int SETTLE_CYC = 3,
    parameter int MAX_RETRY  = 3,
`ifdef OBF_LOCKOUT_EN
    localparam int FCW       = $clog2(MAX_RETRY + 1)
`else
    localparam int FCW       = 2
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         relock,
    input  logic [KEY_LEN*(OPW+DW)-1:0]  key_seq,
    input  logic [DW-1:0]                expect_sig,
    input  logic [DW-1:0]                usr_datain,
    input  logic [OPW-1:0]               usr_op,
    output logic [DW-1:0]                usr_dataout,
    output logic                         usr_valid,
    output logic [DW-1:0]                core_datain,
    output logic [OPW-1:0]               core_op,
    input  logic [DW-1:0]                core_dataout,
    input  logic                         core_valid,
    output logic                         core_rst_req,
    output logic                         busy,
    output logic                         unlocked,
    output logic                         err,
    output logic [FCW-1:0]               fail_cnt
);
    localparam int WW   = OPW + DW;
    localparam int IDXW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam int CNTW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
`ifdef OBF_LOCKOUT_EN
    localparam int FC_MAX = MAX_RETRY;
`else
    localparam int FC_MAX = 3;
`endif

    typedef enum logic [2:0] {
        IDLE, APPLY, SETTLE, CHECK, FAIL, UNLOCKED
`ifdef OBF_LOCKOUT_EN
        , LOCKOUT
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]     usr_dataout_q, usr_dataout_d;
    logic              usr_valid_q, usr_valid_d;
    logic [DW-1:0]     core_datain_q, core_datain_d;
    logic [OPW-1:0]    core_op_q, core_op_d;
    logic              core_rst_req_q, core_rst_req_d;
    logic              busy_q, busy_d;
    logic              unlocked_q, unlocked_d;
    logic              err_q, err_d;
    logic [FCW-1:0]    fail_cnt_q, fail_cnt_d;
    logic [WW-1:0]     key_word;

    assign key_word = key_seq[int'(idx_q)*WW +: WW];

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        usr_dataout_d  = '0;
        usr_valid_d    = 1'b0;
        core_datain_d  = '0;
        core_op_d      = '0;
        core_rst_req_d = 1'b0;
        err_d          = err_q;
        fail_cnt_d     = fail_cnt_q;
        // Status flags follow the state register, so they trail a transition by one cycle.
        busy_d         = (state_q == APPLY) || (state_q == SETTLE) || (state_q == CHECK);
        unlocked_d     = (state_q == UNLOCKED) && !relock;

        case (state_q)
            IDLE: begin
                if (start) begin
                    {core_op_d, core_datain_d} = key_seq[WW-1:0];
                    err_d = 1'b0;
                    if (KEY_LEN == 1) begin
                        state_d = SETTLE;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = APPLY;
                        idx_d   = IDXW'(1);
                    end
                end
            end
            APPLY: begin
                {core_op_d, core_datain_d} = key_word;
                if (idx_q == IDXW'(KEY_LEN - 1)) begin
                    state_d = SETTLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNTW'(SETTLE_CYC - 1))
                    state_d = CHECK;
            end
            CHECK: begin
                if (core_valid && (core_dataout == expect_sig)) begin
                    state_d    = UNLOCKED;
                    fail_cnt_d = '0;
                end else begin
                    state_d = FAIL;
                end
            end
            FAIL: begin
                core_rst_req_d = 1'b1;
                err_d          = 1'b1;
                fail_cnt_d     = (fail_cnt_q == FCW'(FC_MAX)) ? fail_cnt_q : fail_cnt_q + 1'b1;
                state_d        = IDLE;
`ifdef OBF_LOCKOUT_EN
                if (fail_cnt_q >= FCW'(MAX_RETRY - 1))
                    state_d = LOCKOUT;
`endif
            end
            UNLOCKED: begin
                if (relock) begin
                    state_d        = IDLE;
                    core_rst_req_d = 1'b1;
                end else begin
                    core_datain_d = usr_datain;
                    core_op_d     = usr_op;
                    usr_dataout_d = core_dataout;
                    usr_valid_d   = core_valid;
                end
            end
`ifdef OBF_LOCKOUT_EN
            LOCKOUT: err_d = 1'b1;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            cnt_q          <= '0;
            usr_dataout_q  <= '0;
            usr_valid_q    <= 1'b0;
            core_datain_q  <= '0;
            core_op_q      <= '0;
            core_rst_req_q <= 1'b0;
            busy_q         <= 1'b0;
            unlocked_q     <= 1'b0;
            err_q          <= 1'b0;
            fail_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            usr_dataout_q  <= usr_dataout_d;
            usr_valid_q    <= usr_valid_d;
            core_datain_q  <= core_datain_d;
            core_op_q      <= core_op_d;
            core_rst_req_q <= core_rst_req_d;
            busy_q         <= busy_d;
            unlocked_q     <= unlocked_d;
            err_q          <= err_d;
            fail_cnt_q     <= fail_cnt_d;
        end
    end

    assign usr_dataout  = usr_dataout_q;
    assign usr_valid    = usr_valid_q;
    assign core_datain  = core_datain_q;
    assign core_op      = core_op_q;
    assign core_rst_req = core_rst_req_q;
    assign busy         = busy_q;
    assign unlocked     = unlocked_q;
    assign err          = err_q;
    assign fail_cnt     = fail_cnt_q;
endmodule

// File: tb/tb_obf_unlock_sequencer.sv
// Directed bench for obf_unlock_sequencer; build with OBF_LOCKOUT_EN to exercise the lockout path.
module tb_obf_unlock_sequencer;
    localparam int DW = 8;
    localparam int OPW = 2;
    localparam int KEY_LEN = 4;
`ifdef OBF_LOCKOUT_EN
    localparam int FCW = 2;
`else
    localparam int FCW = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic relock = 1'b0;
    logic [KEY_LEN*(OPW+DW)-1:0] key_seq = {10'h381, 10'h0F0, 10'h23C, 10'h1A5};
    logic [DW-1:0] expect_sig = 8'h5A;
    logic [DW-1:0] usr_datain = '0;
    logic [OPW-1:0] usr_op = '0;
    logic [DW-1:0] usr_dataout;
    logic usr_valid;
    logic [DW-1:0] core_datain;
    logic [OPW-1:0] core_op;
    logic [DW-1:0] core_dataout = '0;
    logic core_valid = 1'b0;
    logic core_rst_req, busy, unlocked, err;
    logic [FCW-1:0] fail_cnt;

    int nvec = 0;
    int nerr = 0;
    logic [9:0] exp_words [0:6] = '{10'h1A5, 10'h23C, 10'h0F0, 10'h381, 10'h000, 10'h000, 10'h000};

    obf_unlock_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .relock(relock), .key_seq(key_seq),
        .expect_sig(expect_sig), .usr_datain(usr_datain), .usr_op(usr_op),
        .usr_dataout(usr_dataout), .usr_valid(usr_valid), .core_datain(core_datain),
        .core_op(core_op), .core_dataout(core_dataout), .core_valid(core_valid),
        .core_rst_req(core_rst_req), .busy(busy), .unlocked(unlocked), .err(err),
        .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start pulse plus 8 more cycles lands on the cycle where the CHECK outcome is visible.
    task automatic do_attempt(input logic [DW-1:0] sig);
        core_valid = 1'b1; core_dataout = sig;
        start = 1'b1; tick; start = 1'b0;
        repeat (8) tick;
    endtask

    task automatic test_reset;
        rst = 1'b1; repeat (3) tick; rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            nvec++;
            if ({usr_dataout, usr_valid, core_datain, core_op, core_rst_req, busy, unlocked, err, fail_cnt} !== '0) begin
                nerr++;
                $display("FAIL reset_idle[%0d]: got dout=%h v=%b din=%h op=%h rq=%b busy=%b unl=%b err=%b fc=%0d want all 0",
                         i, usr_dataout, usr_valid, core_datain, core_op, core_rst_req, busy, unlocked, err, fail_cnt);
            end
        end
    endtask

    task automatic test_unlock;
        core_valid = 1'b1; core_dataout = 8'h5A; usr_op = '0; usr_datain = '0;
        start = 1'b1; tick; start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) tick;
            if (k <= 7) begin
                nvec++;
                if ({core_op, core_datain} !== exp_words[k-1]) begin
                    nerr++;
                    $display("FAIL unlock_word[%0d]: got %h want %h", k, {core_op, core_datain}, exp_words[k-1]);
                end
            end
            nvec++;
            if (busy !== (k >= 2 && k <= 8)) begin
                nerr++;
                $display("FAIL unlock_busy[%0d]: got %b want %b", k, busy, (k >= 2 && k <= 8));
            end
            nvec++;
            if (unlocked !== (k == 9)) begin
                nerr++;
                $display("FAIL unlock_flag[%0d]: got %b want %b", k, unlocked, (k == 9));
            end
        end
    endtask

    task automatic test_passthrough;
        usr_op = 2'b01; usr_datain = 8'h33; core_dataout = 8'h44; core_valid = 1'b1;
        tick;
        nvec++;
        if ({core_op, core_datain} !== {2'b01, 8'h33}) begin
            nerr++; $display("FAIL pass_core: got %h want %h", {core_op, core_datain}, {2'b01, 8'h33});
        end
        nvec++;
        if ({usr_valid, usr_dataout} !== {1'b1, 8'h44}) begin
            nerr++; $display("FAIL pass_usr: got %h want %h", {usr_valid, usr_dataout}, {1'b1, 8'h44});
        end
        relock = 1'b1; tick; relock = 1'b0;
        usr_op = '0; usr_datain = '0;
        nvec++;
        if ({core_rst_req, unlocked, usr_valid} !== 3'b100) begin
            nerr++; $display("FAIL relock_pulse: got rq/unl/v=%b want 100", {core_rst_req, unlocked, usr_valid});
        end
        nvec++;
        if ({core_op, core_datain} !== 10'h000) begin
            nerr++; $display("FAIL relock_nop: got %h want 000", {core_op, core_datain});
        end
        tick;
        nvec++;
        if (core_rst_req !== 1'b0) begin
            nerr++; $display("FAIL relock_single: got %b want 0", core_rst_req);
        end
    endtask

    task automatic test_fail;
        do_attempt(8'h00);
        nvec++;
        if ({core_rst_req, err, fail_cnt, unlocked} !== {1'b1, 1'b1, 2'd1, 1'b0}) begin
            nerr++; $display("FAIL fail_flags: got rq/err/fc/unl=%b want 11010", {core_rst_req, err, fail_cnt, unlocked});
        end
        tick;
        nvec++;
        if ({core_rst_req, err, busy} !== 3'b010) begin
            nerr++; $display("FAIL fail_after: got rq/err/busy=%b want 010", {core_rst_req, err, busy});
        end
    endtask

    task automatic test_retry;
        core_valid = 1'b1; core_dataout = 8'h5A;
        start = 1'b1; tick; start = 1'b0;
        nvec++;
        if ({err, fail_cnt} !== {1'b0, 2'd1}) begin
            nerr++; $display("FAIL retry_errclr: got err/fc=%b want 001", {err, fail_cnt});
        end
        repeat (8) tick;
        nvec++;
        if ({unlocked, fail_cnt} !== {1'b1, 2'd0}) begin
            nerr++; $display("FAIL retry_unlock: got unl/fc=%b want 100", {unlocked, fail_cnt});
        end
        relock = 1'b1; tick; relock = 1'b0; tick;
    endtask

    task automatic test_mid_reset;
        do_attempt(8'h00);
        tick;
        core_dataout = 8'h5A;
        start = 1'b1; tick; start = 1'b0;
        tick; tick;
        nvec++;
        if ({core_op, core_datain} !== 10'h0F0) begin
            nerr++; $display("FAIL mid_word2: got %h want 0F0", {core_op, core_datain});
        end
        rst = 1'b1; #2;
        nvec++;
        if ({usr_dataout, usr_valid, core_datain, core_op, core_rst_req, busy, unlocked, err, fail_cnt} !== '0) begin
            nerr++;
            $display("FAIL mid_reset: got din=%h op=%h rq=%b busy=%b err=%b fc=%0d want all 0",
                     core_datain, core_op, core_rst_req, busy, err, fail_cnt);
        end
        @(negedge clk); rst = 1'b0;
        tick;
        nvec++;
        if ({core_rst_req, busy, core_op, core_datain} !== 12'h000) begin
            nerr++; $display("FAIL mid_idle: got rq/busy/word=%h want 000", {core_rst_req, busy, core_op, core_datain});
        end
        start = 1'b1; tick; start = 1'b0;
        nvec++;
        if ({core_op, core_datain} !== 10'h1A5) begin
            nerr++; $display("FAIL replay_w0: got %h want 1A5", {core_op, core_datain});
        end
        tick;
        nvec++;
        if ({core_op, core_datain} !== 10'h23C) begin
            nerr++; $display("FAIL replay_w1: got %h want 23C", {core_op, core_datain});
        end
        rst = 1'b1; tick; rst = 1'b0; tick;
    endtask

`ifndef OBF_LOCKOUT_EN
    task automatic test_saturate;
        logic [1:0] exp_fc [0:3] = '{2'd1, 2'd2, 2'd3, 2'd3};
        for (int i = 0; i < 4; i++) begin
            do_attempt(8'h00);
            nvec++;
            if ({err, fail_cnt} !== {1'b1, exp_fc[i]}) begin
                nerr++; $display("FAIL sat_fc[%0d]: got err/fc=%b want %b", i, {err, fail_cnt}, {1'b1, exp_fc[i]});
            end
        end
        start = 1'b1; tick; start = 1'b0;
        nvec++;
        if ({core_op, core_datain} !== 10'h1A5) begin
            nerr++; $display("FAIL sat_retry: got %h want 1A5", {core_op, core_datain});
        end
        rst = 1'b1; tick; rst = 1'b0; tick;
    endtask
`else
    task automatic test_lockout;
        for (int i = 0; i < 3; i++) do_attempt(8'h00);
        nvec++;
        if ({err, fail_cnt} !== {1'b1, 2'd3}) begin
            nerr++; $display("FAIL lock_enter: got err/fc=%b want 111", {err, fail_cnt});
        end
        start = 1'b1; tick; start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            nvec++;
            if ({core_op, core_datain, busy, err} !== {10'h000, 1'b0, 1'b1}) begin
                nerr++; $display("FAIL lock_quiet[%0d]: got word=%h busy=%b err=%b want 000/0/1", k, {core_op, core_datain}, busy, err);
            end
            tick;
        end
        rst = 1'b1; tick; rst = 1'b0; tick;
        nvec++;
        if ({err, fail_cnt} !== 3'b000) begin
            nerr++; $display("FAIL lock_rst: got err/fc=%b want 000", {err, fail_cnt});
        end
        do_attempt(8'h5A);
        nvec++;
        if (unlocked !== 1'b1) begin
            nerr++; $display("FAIL lock_recover: got %b want 1", unlocked);
        end
        rst = 1'b1; tick; rst = 1'b0; tick;
    endtask
`endif

    initial begin
        test_reset;
        test_unlock;
        test_passthrough;
        test_fail;
        test_retry;
        test_mid_reset;
`ifndef OBF_LOCKOUT_EN
        test_saturate;
`else
        test_lockout;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
